ogr_result_buffer: RTL and testbench



---
 rtl/ogr_result_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_ogr_result_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ogr_result_buffer.sv
// ---------------------------------------------------------------------------
// ogr_result_buffer
//
// Collects candidate Golomb rulers from the search engine. Every ruler that
// ties the shortest length seen so far is kept (MODE 0). In MODE 1 every
// accepted ruler is kept. After the search reports done, the stored rulers
// are streamed to the host one mark per beat.
//
// Ports
//   clock, RESET_IN        : clock, synchronous active-high reset
//   in_ruler/in_valid      : candidate ruler (mark 0 in the MSBs)
//   in_ready               : high while collecting
//   search_done            : pulse, collection ends
//   rd_start               : pulse, begin a readout stream
//   out_mark/out_valid     : streamed mark and its qualifier
//   out_ready              : host accepts the beat
//   out_last               : final mark of the final stored ruler
//   rd_done                : one-cycle pulse after a stream completes
//   best_len               : last mark of the best ruler so far
//   num_stored             : occupied slots
//   numResultsObserved     : saturating count of matching accepted rulers
//   overflow               : sticky, a qualifying ruler found no free slot
//   done                   : high once collection has ended
//   dbg_state_o            : FSM state (0 COLLECT, 1 READY, 2 STREAM)
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready;
// out_mark/out_valid stay unchanged while out_ready is low. A candidate is
// taken on an edge where in_valid && in_ready.
// ---------------------------------------------------------------------------
module ogr_result_buffer #(
    parameter int NUM_MARKS = 6,
    parameter int POS_W     = 9,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 6,
    parameter int MODE      = 0
) (
    input  logic                          clock,
    input  logic                          RESET_IN,
    input  logic [NUM_MARKS*POS_W-1:0]    in_ruler,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          search_done,
    input  logic                          rd_start,
    output logic [POS_W-1:0]              out_mark,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          rd_done,
    output logic [POS_W-1:0]              best_len,
    output logic [$clog2(DEPTH+1)-1:0]    num_stored,
    output logic [CNT_W-1:0]              numResultsObserved,
    output logic                          overflow,
    output logic                          done,
    output logic [1:0]                    dbg_state_o
);

    localparam int RW   = NUM_MARKS * POS_W;
    localparam int NS_W = $clog2(DEPTH + 1);
    localparam int SI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MI_W = (NUM_MARKS > 1) ? $clog2(NUM_MARKS) : 1;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_READY   = 2'd1,
        S_STREAM  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     slots_q [DEPTH];
    logic [POS_W-1:0]  best_len_q, best_len_d;
    logic [NS_W-1:0]   num_stored_q, num_stored_d;
    logic [CNT_W-1:0]  obs_q, obs_d;
    logic              overflow_q, overflow_d;
    logic              rd_done_q, rd_done_d;
    logic [SI_W-1:0]   slot_idx_q, slot_idx_d;
    logic [MI_W-1:0]   mark_idx_q, mark_idx_d;

    logic              accept;
    logic [POS_W-1:0]  cand_len;
    logic              has_space;
    logic              beat;
    logic              last_beat;
    logic [CNT_W-1:0]  obs_inc;
    logic              wr_en;
    logic              clr_slots;
    logic [SI_W-1:0]   wr_idx;
    logic [RW-1:0]     slot_word;

    assign accept    = (state_q == S_COLLECT) && in_valid;
    assign cand_len  = in_ruler[POS_W-1:0];
    assign has_space = num_stored_q < NS_W'(DEPTH);
    // out_valid is exactly "in STREAM", so a handshake only needs out_ready.
    assign beat      = (state_q == S_STREAM) && out_ready;
    assign last_beat = (mark_idx_q == MI_W'(NUM_MARKS - 1)) &&
                       ((NS_W'(slot_idx_q) + NS_W'(1)) == num_stored_q);
    assign obs_inc   = (obs_q == {CNT_W{1'b1}}) ? obs_q : obs_q + CNT_W'(1);
    assign slot_word = slots_q[slot_idx_q];

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (RESET_IN) begin
            state_q      <= S_COLLECT;
            best_len_q   <= '1;
            num_stored_q <= '0;
            obs_q        <= '0;
            overflow_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            slot_idx_q   <= '0;
            mark_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            best_len_q   <= best_len_d;
            num_stored_q <= num_stored_d;
            obs_q        <= obs_d;
            overflow_q   <= overflow_d;
            rd_done_q    <= rd_done_d;
            slot_idx_q   <= slot_idx_d;
            mark_idx_q   <= mark_idx_d;
        end
    end

    // Slot storage; a new best first wipes every slot, then lands in slot 0.
    always_ff @(posedge clock) begin
        if (RESET_IN) begin
            for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
        end else begin
            if (clr_slots) begin
                for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
            end
            if (wr_en) slots_q[wr_idx] <= in_ruler;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (search_done) state_d = S_READY;
            S_READY:   if (rd_start && (num_stored_q != '0)) state_d = S_STREAM;
            S_STREAM:  if (beat && last_beat) state_d = S_READY;
            default:   state_d = S_COLLECT;
        endcase
    end

    // Collection and readout datapath.
    always_comb begin
        best_len_d   = best_len_q;
        num_stored_d = num_stored_q;
        obs_d        = obs_q;
        overflow_d   = overflow_q;
        rd_done_d    = 1'b0;
        slot_idx_d   = slot_idx_q;
        mark_idx_d   = mark_idx_q;
        wr_en        = 1'b0;
        clr_slots    = 1'b0;
        wr_idx       = SI_W'(num_stored_q);

        if (accept) begin
            if (MODE == 0) begin
                if (cand_len < best_len_q) begin
                    clr_slots    = 1'b1;
                    wr_en        = 1'b1;
                    wr_idx       = '0;
                    num_stored_d = NS_W'(1);
                    obs_d        = CNT_W'(1);
                    best_len_d   = cand_len;
                    overflow_d   = 1'b0;
                end else if (cand_len == best_len_q) begin
                    if (has_space) begin
                        wr_en        = 1'b1;
                        num_stored_d = num_stored_q + NS_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    obs_d = obs_inc;
                end
            end else begin
                obs_d = obs_inc;
                if (has_space) begin
                    wr_en        = 1'b1;
                    num_stored_d = num_stored_q + NS_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                if (cand_len < best_len_q) best_len_d = cand_len;
            end
        end

        if ((state_q == S_READY) && rd_start) begin
            if (num_stored_q == '0) begin
                rd_done_d = 1'b1;
            end else begin
                slot_idx_d = '0;
                mark_idx_d = '0;
            end
        end

        if (beat) begin
            if (last_beat) begin
                rd_done_d = 1'b1;
            end else if (mark_idx_q == MI_W'(NUM_MARKS - 1)) begin
                mark_idx_d = '0;
                slot_idx_d = slot_idx_q + SI_W'(1);
            end else begin
                mark_idx_d = mark_idx_q + MI_W'(1);
            end
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready           = (state_q == S_COLLECT);
        done               = (state_q != S_COLLECT);
        out_valid          = (state_q == S_STREAM);
        out_last           = (state_q == S_STREAM) && last_beat;
        out_mark           = '0;
        if (state_q == S_STREAM) begin
            for (int m = 0; m < NUM_MARKS; m++) begin
                if (mark_idx_q == MI_W'(m)) out_mark = slot_word[(NUM_MARKS-1-m)*POS_W +: POS_W];
            end
        end
        rd_done            = rd_done_q;
        best_len           = best_len_q;
        num_stored         = num_stored_q;
        numResultsObserved = obs_q;
        overflow           = overflow_q;
        dbg_state_o        = state_q;
    end

endmodule

// File: tb/tb_ogr_result_buffer.sv
module tb_ogr_result_buffer;

  localparam int NM    = 6;
  localparam int PW    = 9;
  localparam int DEPTH = 4;
  localparam int CW    = 6;
  localparam int RW    = NM * PW;
  localparam int NSW   = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          RESET_IN = 1'b1;
  logic [RW-1:0] in_ruler = '0;
  logic          in_valid = 1'b0;
  logic          search_done = 1'b0;
  logic          rd_start = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready0, out_valid0, out_last0, rd_done0, overflow0, done0;
  logic [PW-1:0] out_mark0, best_len0;
  logic [NSW-1:0] num_stored0;
  logic [CW-1:0] obs0;
  logic [1:0]    state0;

  logic          in_ready1, out_valid1, out_last1, rd_done1, overflow1, done1;
  logic [PW-1:0] out_mark1, best_len1;
  logic [NSW-1:0] num_stored1;
  logic [CW-1:0] obs1;
  logic [1:0]    state1;

  ogr_result_buffer #(.NUM_MARKS(NM), .POS_W(PW), .DEPTH(DEPTH), .CNT_W(CW), .MODE(0)) dut0 (
    .clock(clock), .RESET_IN(RESET_IN), .in_ruler(in_ruler), .in_valid(in_valid),
    .in_ready(in_ready0), .search_done(search_done), .rd_start(rd_start),
    .out_mark(out_mark0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .rd_done(rd_done0), .best_len(best_len0),
    .num_stored(num_stored0), .numResultsObserved(obs0), .overflow(overflow0),
    .done(done0), .dbg_state_o(state0)
  );

  ogr_result_buffer #(.NUM_MARKS(NM), .POS_W(PW), .DEPTH(DEPTH), .CNT_W(CW), .MODE(1)) dut1 (
    .clock(clock), .RESET_IN(RESET_IN), .in_ruler(in_ruler), .in_valid(in_valid),
    .in_ready(in_ready1), .search_done(search_done), .rd_start(rd_start),
    .out_mark(out_mark1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .rd_done(rd_done1), .best_len(best_len1),
    .num_stored(num_stored1), .numResultsObserved(obs1), .overflow(overflow1),
    .done(done1), .dbg_state_o(state1)
  );

  // ---------------- scoreboard / models ----------------
  logic [PW-1:0] exp_q[$];
  logic [RW-1:0] m0_slots[$];
  logic [RW-1:0] m1_slots[$];
  logic [PW-1:0] m0_best, m1_best;
  int            m0_obs, m1_obs;
  logic          m0_ovf, m1_ovf;
  bit            m_collect;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
    mk = {PW'(a), PW'(b), PW'(c), PW'(d), PW'(e), PW'(f)};
  endfunction

  task automatic model_reset();
    m0_slots.delete(); m1_slots.delete();
    m0_best = '1; m1_best = '1;
    m0_obs = 0; m1_obs = 0;
    m0_ovf = 1'b0; m1_ovf = 1'b0;
    m_collect = 1'b1;
  endtask

  task automatic model_accept(input logic [RW-1:0] r);
    logic [PW-1:0] l;
    l = r[PW-1:0];
    if (!m_collect) return;
    if (l < m0_best) begin
      m0_slots.delete(); m0_slots.push_back(r);
      m0_obs = 1; m0_best = l; m0_ovf = 1'b0;
    end else if (l == m0_best) begin
      if (m0_slots.size() < DEPTH) m0_slots.push_back(r); else m0_ovf = 1'b1;
      if (m0_obs < (1 << CW) - 1) m0_obs++;
    end
    if (m1_slots.size() < DEPTH) m1_slots.push_back(r); else m1_ovf = 1'b1;
    if (m1_obs < (1 << CW) - 1) m1_obs++;
    if (l < m1_best) m1_best = l;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    RESET_IN = 1'b1;
    in_valid = 1'b0; search_done = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    model_reset();
    RESET_IN = 1'b0;
  endtask

  task automatic feed(input logic [RW-1:0] r, input bit with_done);
    in_ruler = r; in_valid = 1'b1; search_done = with_done;
    tick();
    in_valid = 1'b0; search_done = 1'b0;
    model_accept(r);
    if (with_done) m_collect = 1'b0;
  endtask

  task automatic finish_search();
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    m_collect = 1'b0;
  endtask

  task automatic check_model0(input string tag);
    check({tag, "_best"}, best_len0, m0_best);
    check({tag, "_nstored"}, num_stored0, m0_slots.size());
    check({tag, "_observed"}, obs0, m0_obs);
    check({tag, "_overflow"}, overflow0, m0_ovf);
  endtask

  // Streams the selected instance; expected beats come from the bench model.
  task automatic run_stream(input bit sel, input bit toggle,
                            output int beats, output int pulses, output int cycles);
    logic [RW-1:0] r;
    logic v, lst, rdd, dn;
    logic [PW-1:0] mark;
    int n;
    exp_q.delete();
    n = sel ? m1_slots.size() : m0_slots.size();
    for (int s = 0; s < n; s++) begin
      r = sel ? m1_slots[s] : m0_slots[s];
      for (int m = 0; m < NM; m++) exp_q.push_back(r[(NM-1-m)*PW +: PW]);
    end
    beats = 0; pulses = 0; cycles = 0;
    out_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (cycles < 200) begin
      v    = sel ? out_valid1 : out_valid0;
      mark = sel ? out_mark1  : out_mark0;
      lst  = sel ? out_last1  : out_last0;
      rdd  = sel ? rd_done1   : rd_done0;
      dn   = sel ? done1      : done0;
      check("done_during_stream", dn, 1);
      if (rdd) pulses++;
      if (v) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", v, 0);
        end else begin
          check("beat_mark", mark, exp_q[0]);
          check("beat_last", lst, exp_q.size() == 1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (exp_q.size() == 0 && pulses > 0) break;
      tick();
      cycles++;
      if (toggle) out_ready = ~out_ready;
    end
    out_ready = 1'b0;
    tick();
    check("rd_done_single", sel ? rd_done1 : rd_done0, 0);
    check("valid_after_stream", sel ? out_valid1 : out_valid0, 0);
    check("ready_state_after", sel ? state1 : state0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [RW-1:0] ra, rb, rc, rd, re, rf;
    int beats, pulses, cycles;
    ra = mk(0, 1, 3, 7, 12, 20);
    rb = mk(0, 1, 4, 10, 12, 17);
    rc = mk(0, 2, 5, 9, 15, 21);
    rd = mk(0, 1, 4, 10, 15, 17);
    re = mk(0, 1, 8, 11, 13, 17);
    rf = mk(0, 2, 7, 13, 16, 17);

    // Reset values
    RESET_IN = 1'b1;
    tick();
    check("rst_best", best_len0, 511);
    check("rst_nstored", num_stored0, 0);
    check("rst_observed", obs0, 0);
    check("rst_overflow", overflow0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_last", out_last0, 0);
    check("rst_out_mark", out_mark0, 0);
    check("rst_rd_done", rd_done0, 0);
    check("rst_done", done0, 0);
    do_reset();
    check("rst_in_ready", in_ready0, 1);
    check("rst_in_ready_m1", in_ready1, 1);

    // Ruler-length ordering
    feed(ra, 0);
    check("order_first_best", best_len0, 20);
    feed(rb, 0);
    feed(rc, 0);
    check("order_best", best_len0, 17);
    check("order_nstored", num_stored0, 1);
    check("order_observed", obs0, 1);
    check_model0("order");

    // Ties and overflow
    do_reset();
    feed(rb, 0); feed(rd, 0); feed(re, 0); feed(rf, 0);
    check("ties_nstored", num_stored0, 4);
    check("ties_overflow_clear", overflow0, 0);
    feed(rb, 0);
    check("ties_nstored_full", num_stored0, 4);
    check("ties_observed", obs0, 5);
    check("ties_overflow", overflow0, 1);
    check_model0("ties");

    // Finish search; inputs ignored in READY
    finish_search();
    check("ready_done", done0, 1);
    check("ready_in_ready", in_ready0, 0);
    check("ready_state", state0, 1);
    feed(mk(0, 1, 2, 3, 4, 5), 1);
    check("ready_ignore_len", best_len0, 17);
    check_model0("ready_ignore");

    // Readout with backpressure, then an unthrottled replay
    run_stream(0, 1, beats, pulses, cycles);
    check("bp_beats", beats, 24);
    check("bp_rd_done_pulses", pulses, 1);
    run_stream(0, 0, beats, pulses, cycles);
    check("replay_beats", beats, 24);
    check("replay_rd_done_pulses", pulses, 1);
    check("replay_cycles", cycles, 24);

    // Empty buffer
    do_reset();
    finish_search();
    run_stream(0, 0, beats, pulses, cycles);
    check("empty_beats", beats, 0);
    check("empty_rd_done_pulses", pulses, 1);
    check("empty_rd_done_latency", cycles, 0);
    check("empty_best", best_len0, 511);

    // Candidate and search_done in the same cycle
    do_reset();
    feed(rb, 1);
    check("same_done", done0, 1);
    check("same_nstored", num_stored0, 1);
    check("same_best", best_len0, 17);
    feed(ra, 0);
    check("same_later_ignored", num_stored0, 1);
    check_model0("same");

    // Reset in the middle of a stream
    do_reset();
    feed(rb, 0); feed(rd, 0);
    finish_search();
    out_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_valid_before", out_valid0, 1);
    check("mid_beat8_mark", out_mark0, 1);
    RESET_IN = 1'b1;
    out_ready = 1'b0;
    tick();
    check("mid_valid_after", out_valid0, 0);
    check("mid_nstored", num_stored0, 0);
    check("mid_observed", obs0, 0);
    check("mid_overflow", overflow0, 0);
    check("mid_best", best_len0, 511);
    check("mid_done", done0, 0);
    RESET_IN = 1'b0;
    model_reset();
    tick();
    check("mid_in_ready", in_ready0, 1);

    // Keep-all mode
    feed(ra, 0);
    feed(rb, 0);
    check("m1_best", best_len1, 17);
    check("m1_observed", obs1, 2);
    check("m1_nstored", num_stored1, 2);
    check("m1_overflow", overflow1, 0);
    check("m1_vs_m0_nstored", num_stored0, 1);
    check("m1_model_obs", obs1, m1_obs);
    finish_search();
    run_stream(1, 0, beats, pulses, cycles);
    check("m1_beats", beats, 12);
    check("m1_rd_done_pulses", pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
